// File: rtl/pc_module_if.sv
// Purpose: next-PC selection bus between the fetch control and pc_module.
// Signals (named from the pc_module side):
//   i_pc_src      2      next-PC select: 00 PC+INC, 01 return address, 10 jump, 11 branch
//   i_i_imm       WIDTH  sign-extended branch offset, relative to the current PC
//   i_j_imm       WIDTH  sign-extended jump offset, relative to the current PC
//   i_ret_addr    WIDTH  absolute return target
//   o_pc          WIDTH  current program counter (registered)
interface pc_module_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       i_pc_src;
    logic [WIDTH-1:0] i_i_imm;
    logic [WIDTH-1:0] i_j_imm;
    logic [WIDTH-1:0] i_ret_addr;
    logic [WIDTH-1:0] o_pc;

    modport master (
        output i_pc_src,
        output i_i_imm,
        output i_j_imm,
        output i_ret_addr,
        input  o_pc
    );

    modport slave (
        input  i_pc_src,
        input  i_i_imm,
        input  i_j_imm,
        input  i_ret_addr,
        output o_pc
    );
endinterface

// File: rtl/pc_module.sv
// Purpose: program-counter register and next-PC selection for instruction fetch.
// Ports:
//   i_clk    in   single clock, PC updates on the rising edge
//   i_rst_n  in   asynchronous active-low reset, forces PC to RESET_PC at once
//   io_bus   slave modport of pc_module_if (select, offsets, return address, PC out)
module pc_module #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    pc_module_if.slave    io_bus
);
    localparam logic [1:0] PC_SRC_RA  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;
    localparam logic [1:0] PC_SRC_BTA = 2'b11;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_jta;
    logic [WIDTH-1:0] w_bta;
    logic [WIDTH-1:0] w_next_pc;

    // Candidate targets; offsets are relative to the current PC, wrap modulo 2^WIDTH.
    assign w_pc_plus = r_pc + PC_INC;
    assign w_jta     = r_pc + io_bus.i_j_imm;
    assign w_bta     = r_pc + io_bus.i_i_imm;

    // Priority-free 4:1 select; an unknown select propagates X in simulation,
    // while the final fallback leg makes hardware default to PC+INC.
    assign w_next_pc = (io_bus.i_pc_src == PC_SRC_BTA) ? w_bta :
                       (io_bus.i_pc_src == PC_SRC_JMP) ? w_jta :
                       (io_bus.i_pc_src == PC_SRC_RA)  ? io_bus.i_ret_addr :
                                                         w_pc_plus;

    // PC register; reset dominates any edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign io_bus.o_pc = r_pc;
endmodule

// File: tb/tb_pc_module.sv
// Purpose: randomized scoreboard bench for pc_module against an arithmetic reference model.
module tb_pc_module;
    localparam int unsigned WIDTH = 32;

    logic i_clk;
    logic i_rst_n;

    pc_module_if #(.WIDTH(WIDTH)) bus ();

    pc_module #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .io_bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model_pc;

    // 10 ns clock, starts low, first rising edge at 5 ns.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: next PC from the select rules, wrapped to 2^WIDTH.
    function automatic logic [WIDTH-1:0] ref_next(input logic [WIDTH-1:0] pc,
                                                  input logic [1:0] src,
                                                  input logic [WIDTH-1:0] ra,
                                                  input logic [WIDTH-1:0] j,
                                                  input logic [WIDTH-1:0] i);
        longint sum;
        case (src)
            2'd0:    sum = longint'(pc) + 1;
            2'd1:    sum = longint'(ra);
            2'd2:    sum = longint'(pc) + longint'($signed(j));
            default: sum = longint'(pc) + longint'($signed(i));
        endcase
        return WIDTH'(sum & 64'hFFFF_FFFF);
    endfunction

    // Drive one cycle's inputs (at a falling edge) and queue the PC expected after the next rise.
    task automatic step(input logic [1:0] src, input logic [WIDTH-1:0] ra,
                        input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] i);
        bus.i_pc_src   = src;
        bus.i_ret_addr = ra;
        bus.i_j_imm    = j;
        bus.i_i_imm    = i;
        model_pc = ref_next(model_pc, src, ra, j, i);
        exp_q.push_back(model_pc);
        @(negedge i_clk);
    endtask

    // Monitor: PC is presented after every rising edge while out of reset.
    always @(posedge i_clk) begin
        #1;
        if (i_rst_n && exp_q.size() > 0) begin
            check("pc_scoreboard", bus.o_pc, exp_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]       src;
        logic [WIDTH-1:0] ra, j, i;

        i_rst_n        = 1'b0;
        bus.i_pc_src   = 2'b00;
        bus.i_ret_addr = '0;
        bus.i_j_imm    = '0;
        bus.i_i_imm    = '0;
        model_pc       = '0;

        // Reset held across the first edge.
        #2;
        check("reset_t0", bus.o_pc, 32'h0);
        @(posedge i_clk);
        #1;
        check("reset_edge", bus.o_pc, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Sequential 1,2,3.
        repeat (3) step(2'b00, '0, '0, '0);
        // Back to 0 via return address, then Dft -> 1, Ra 2 -> 2.
        step(2'b01, 32'h0, '0, '0);
        step(2'b00, '0, '0, '0);
        step(2'b01, 32'h2, '0, '0);
        // Jmp +10 -> 12, Jmp -10 -> 2.
        step(2'b10, '0, 32'd10, '0);
        step(2'b10, '0, -32'sd10, '0);
        // BTA +8 -> 10, Dft -> 11.
        step(2'b11, '0, '0, 32'd8);
        step(2'b00, '0, '0, '0);
        // Wrap: to 0, Jmp -1 -> FFFF_FFFF, Dft -> 0.
        step(2'b01, 32'h0, '0, '0);
        step(2'b10, '0, 32'hFFFF_FFFF, '0);
        step(2'b00, '0, '0, '0);
        // Zero offset holds PC; negative branch moves back.
        step(2'b01, 32'h100, '0, '0);
        step(2'b10, '0, 32'h0, '0);
        step(2'b11, '0, '0, 32'h0);
        step(2'b11, '0, '0, -32'sd16);

        // Randomized mix of small signed offsets and full-range values.
        for (int k = 0; k < 300; k++) begin
            src = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                j = WIDTH'($signed(32'($urandom_range(0, 64))) - 32);
                i = WIDTH'($signed(32'($urandom_range(0, 64))) - 32);
            end else begin
                j = $urandom;
                i = $urandom;
            end
            step(src, ra, j, i);
        end

        // Asynchronous reset between edges while PC = 10.
        step(2'b01, 32'd10, '0, '0);
        check("pc_before_reset", bus.o_pc, 32'd10);
        bus.i_pc_src = 2'b10;
        bus.i_j_imm  = 32'd5;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", bus.o_pc, 32'h0);
        repeat (2) begin
            @(posedge i_clk);
            #1;
            check("reset_hold", bus.o_pc, 32'h0);
        end
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        model_pc = '0;
        step(2'b00, '0, '0, '0);
        step(2'b10, '0, 32'd20, '0);
        step(2'b11, '0, '0, -32'sd3);

        @(negedge i_clk);
        check("queue_drained", WIDTH'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
